// File: rtl/dct_row_mac.sv
// ---------------------------------------------------------------------------
// dct_row_mac -- 8-point 1-D DCT row engine
//
// Collects eight 8-bit pixels into a row buffer. It then reads the DCT
// coefficient ROM two rows at a time, using both ports: (0,4), (1,5), (2,6),
// (3,7). It forms eight signed dot products and streams the scaled results
// y[0..7] to the next stage with a valid/ready handshake.
//
// Optional feature (compile-time macro DCT_LEVEL_SHIFT_EN):
//   defined   : each pixel is stored as in_data - 128 (JPEG level shift)
//   undefined : each pixel is stored zero-extended, {1'b0, in_data}
//
// Parameters:
//   SHIFT       arithmetic right shift of the 20-bit accumulator
//               (OUT_W = 20 - SHIFT)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    pixel offered
//   in_data     unsigned 8-bit pixel
//   in_ready    pixel accepted this cycle when in_valid is also high
//   coef_addr1  ROM port-1 row address (0 outside COMPUTE)
//   coef_addr2  ROM port-2 row address (0 outside COMPUTE)
//   coef_row1   ROM port-1 data, two cycles after coef_addr1
//   coef_row2   ROM port-2 data, two cycles after coef_addr2
//   out_valid   result present
//   out_data    signed result y[k], OUT_W bits
//   out_idx     k of out_data
//   out_ready   downstream accepts the result
// ---------------------------------------------------------------------------
module dct_row_mac #(
    parameter int SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic [2:0]          coef_addr1,
    output logic [2:0]          coef_addr2,
    input  logic [63:0]         coef_row1,
    input  logic [63:0]         coef_row2,
    output logic                out_valid,
    output logic [19-SHIFT:0]   out_data,
    output logic [2:0]          out_idx,
    input  logic                out_ready
);

    localparam int OUT_W = 20 - SHIFT;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;     // pixel write index in LOAD
    logic [2:0]              cyc_q, cyc_d;     // cycle within COMPUTE, 0..5
    logic [2:0]              idx_q, idx_d;     // output index k in DRAIN
    logic signed [8:0]       x_q [8];
    logic [OUT_W-1:0]        r_q [8];

    logic                    load_fire;
    logic                    mac_en;
    logic [1:0]              pass;
    logic signed [8:0]       pix_ext;

    // ------------------------------------------------------------------
    // Sample extension
    // ------------------------------------------------------------------
`ifdef DCT_LEVEL_SHIFT_EN
    // in_data - 128: flipping the MSB gives the 8-bit two's-complement
    // value. The flipped bit is then copied as the sign of the 9-bit value.
    assign pix_ext = {~in_data[7], ~in_data[7], in_data[6:0]};
`else
    assign pix_ext = {1'b0, in_data};
`endif

    // ------------------------------------------------------------------
    // Dot products for the two coefficient rows arriving this cycle
    // ------------------------------------------------------------------
    logic signed [16:0] prod1 [8];
    logic signed [16:0] prod2 [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mul
            // Byte n of a ROM row sits at bits [63-8n -: 8].
            assign prod1[gi] = 17'(x_q[gi]) * 17'($signed(coef_row1[63-8*gi -: 8]));
            assign prod2[gi] = 17'(x_q[gi]) * 17'($signed(coef_row2[63-8*gi -: 8]));
        end
    endgenerate

    logic signed [19:0] sum1, sum2;
    logic signed [19:0] sh1, sh2;

    always_comb begin
        sum1 = '0;
        sum2 = '0;
        for (int i = 0; i < 8; i++) begin
            sum1 = sum1 + 20'(prod1[i]);
            sum2 = sum2 + 20'(prod2[i]);
        end
        // Arithmetic shift rounds toward minus infinity.
        sh1 = sum1 >>> SHIFT;
        sh2 = sum2 >>> SHIFT;
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign load_fire = (state_q == ST_LOAD) && in_valid;
    // ROM data for the address issued in COMPUTE cycle c is valid in
    // cycle c+2. Passes 0..3 are therefore accumulated in cycles 2..5.
    assign mac_en    = (state_q == ST_COMPUTE) && (cyc_q >= 3'd2);
    assign pass      = cyc_q[1:0] - 2'd2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = 3'd0;
                        cyc_d   = 3'd0;
                    end
                end
            end
            ST_COMPUTE: begin
                cyc_d = cyc_q + 3'd1;
                if (cyc_q == 3'd5) begin
                    state_d = ST_DRAIN;
                    cyc_d   = 3'd0;
                    idx_d   = 3'd0;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_LOAD;
                        idx_d   = 3'd0;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 3'd0;
                cyc_d   = 3'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= 3'd0;
            cyc_q   <= 3'd0;
            idx_q   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                x_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            if (load_fire) begin
                x_q[cnt_q] <= pix_ext;
            end
            if (mac_en) begin
                r_q[{1'b0, pass}] <= sh1[OUT_W-1:0];
                r_q[{1'b1, pass}] <= sh2[OUT_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_DRAIN);
    assign out_idx    = idx_q;
    assign out_data   = (state_q == ST_DRAIN) ? r_q[idx_q] : '0;

    // Addresses are issued only in the first four COMPUTE cycles. They are
    // parked at 0 at all other times.
    assign coef_addr1 = ((state_q == ST_COMPUTE) && (cyc_q < 3'd4)) ? {1'b0, cyc_q[1:0]} : 3'd0;
    assign coef_addr2 = ((state_q == ST_COMPUTE) && (cyc_q < 3'd4)) ? {1'b1, cyc_q[1:0]} : 3'd0;

endmodule
